// File: rtl/conv_axi_rd_arbiter_if.sv
// rtl/conv_axi_rd_arbiter_if.sv - requester-side and shared-port AXI4 read signals of the convolution read arbiter
interface conv_axi_rd_arbiter_if #(
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32
);
    logic [3*AXI_WIDTH_ID-1:0] S_ARID;
    logic [3*AXI_WIDTH_AD-1:0] S_ARADDR;
    logic [3*8-1:0]            S_ARLEN;
    logic [3*3-1:0]            S_ARSIZE;
    logic [3*2-1:0]            S_ARBURST;
    logic [2:0]                S_ARVALID;
    logic [2:0]                S_ARREADY;
    logic [AXI_WIDTH_ID-1:0]   S_RID;
    logic [AXI_WIDTH_DA-1:0]   S_RDATA;
    logic [1:0]                S_RRESP;
    logic                      S_RLAST;
    logic [2:0]                S_RVALID;
    logic [2:0]                S_RREADY;

    logic [AXI_WIDTH_ID+1:0]   M_ARID;
    logic [AXI_WIDTH_AD-1:0]   M_ARADDR;
    logic [7:0]                M_ARLEN;
    logic [2:0]                M_ARSIZE;
    logic [1:0]                M_ARBURST;
    logic                      M_ARVALID;
    logic                      M_ARREADY;
    logic [AXI_WIDTH_ID+1:0]   M_RID;
    logic [AXI_WIDTH_DA-1:0]   M_RDATA;
    logic [1:0]                M_RRESP;
    logic                      M_RLAST;
    logic                      M_RVALID;
    logic                      M_RREADY;

    // The arbiter's view: slave to the three requesters, master on the shared port.
    modport master (
        input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
        output S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
        output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY,
        input  M_ARREADY, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID
    );

    modport slave (
        output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
        input  S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
        input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY,
        output M_ARREADY, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID
    );
endinterface

// File: rtl/conv_axi_rd_arbiter.sv
// rtl/conv_axi_rd_arbiter.sv - round-robin AXI4 read arbiter for the kernel/feature/channel masters
module conv_axi_rd_arbiter #(
    parameter int AXI_WIDTH_ID    = 4,
    parameter int AXI_WIDTH_AD    = 32,
    parameter int AXI_WIDTH_DA    = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    conv_axi_rd_arbiter_if.master        bus,
    output logic                         busy,
    output logic                         rid_err
);
    localparam int IW = AXI_WIDTH_ID;
    localparam int AW = AXI_WIDTH_AD;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t     state, state_nxt;
    logic [1:0] rr_ptr;
    logic [3:0] outst [3];
    logic [2:0] elig;
    logic [2:0] cand;
    logic       grant_vld;
    logic [1:0] grant;
    logic       accept;
    logic [1:0] r_idx;
    logic       r_beat;
    logic [3:0] outst_zero;
    logic [2:0] cnt_inc, cnt_dec;

    always_comb begin
        elig      = '0;
        cand      = '0;
        grant_vld = 1'b0;
        grant     = 2'd0;
        for (int i = 0; i < 3; i++) begin
            elig[i] = bus.S_ARVALID[i] && (outst[i] < 4'(MAX_OUTSTANDING));
        end
        // First eligible requester at or above the pointer, wrapping mod 3.
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!grant_vld && elig[cand[1:0]]) begin
                grant_vld = 1'b1;
                grant     = cand[1:0];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.S_ARREADY = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    accept        = 1'b1;
                    bus.S_ARREADY = 3'b001 << grant;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.M_ARREADY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.M_ARVALID = (state == ISSUE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bus.M_ARID    <= '0;
            bus.M_ARADDR  <= '0;
            bus.M_ARLEN   <= '0;
            bus.M_ARSIZE  <= '0;
            bus.M_ARBURST <= '0;
            rr_ptr        <= 2'd0;
        end else if (accept) begin
            bus.M_ARID    <= {grant, bus.S_ARID[int'(grant)*IW +: IW]};
            bus.M_ARADDR  <= bus.S_ARADDR[int'(grant)*AW +: AW];
            bus.M_ARLEN   <= bus.S_ARLEN[int'(grant)*8 +: 8];
            bus.M_ARSIZE  <= bus.S_ARSIZE[int'(grant)*3 +: 3];
            bus.M_ARBURST <= bus.S_ARBURST[int'(grant)*2 +: 2];
            rr_ptr        <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
        end
    end

    // R path is pure steering; the top two ID bits name the requester.
    assign r_idx       = bus.M_RID[IW+1:IW];
    assign r_beat      = bus.M_RVALID && bus.M_RREADY;
    assign bus.S_RID   = bus.M_RID[IW-1:0];
    assign bus.S_RDATA = bus.M_RDATA;
    assign bus.S_RRESP = bus.M_RRESP;
    assign bus.S_RLAST = bus.M_RLAST;

    always_comb begin
        bus.S_RVALID = '0;
        bus.M_RREADY = 1'b1;
        case (r_idx)
            2'd0: begin bus.S_RVALID = {2'b00, bus.M_RVALID};       bus.M_RREADY = bus.S_RREADY[0]; end
            2'd1: begin bus.S_RVALID = {1'b0, bus.M_RVALID, 1'b0};  bus.M_RREADY = bus.S_RREADY[1]; end
            2'd2: begin bus.S_RVALID = {bus.M_RVALID, 2'b00};       bus.M_RREADY = bus.S_RREADY[2]; end
            default: ;
        endcase
    end

    always_comb begin
        outst_zero = 4'b0000;
        cnt_inc    = '0;
        cnt_dec    = '0;
        for (int i = 0; i < 3; i++) begin
            outst_zero[i] = (outst[i] == 4'd0);
            cnt_inc[i]    = accept && (grant == 2'(i));
            // A stray RLAST on an idle requester must not wrap its counter.
            cnt_dec[i]    = r_beat && bus.M_RLAST && (r_idx == 2'(i)) && !outst_zero[i];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 3; i++) outst[i] <= 4'd0;
            rid_err <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                case ({cnt_inc[i], cnt_dec[i]})
                    2'b10:   outst[i] <= outst[i] + 4'd1;
                    2'b01:   outst[i] <= outst[i] - 4'd1;
                    default: outst[i] <= outst[i];
                endcase
            end
            rid_err <= r_beat && ((r_idx == 2'd3) || (bus.M_RLAST && outst_zero[r_idx]));
        end
    end

    assign busy = (state != IDLE) || !(&outst_zero[2:0]);
endmodule

// File: tb/tb_conv_axi_rd_arbiter.sv
// tb/tb_conv_axi_rd_arbiter.sv - randomized scoreboard bench for conv_axi_rd_arbiter
module tb_conv_axi_rd_arbiter;
    localparam int MAXO = 4;

    typedef struct {
        int         req;
        logic [3:0] id;
        logic [31:0] addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_t;

    typedef struct {
        logic [5:0] rid;
        int         left;
    } burst_t;

    typedef struct {
        logic [2:0]  arready;
        logic [2:0]  rvalid;
        logic        mrready;
        logic        arvalid;
        logic        busy;
        logic        err_next;
        logic        rst;
        logic [31:0] rdata;
        logic [3:0]  rid;
    } ent_t;

    logic ACLK = 1'b0;
    logic ARESET;
    logic busy, rid_err;

    conv_axi_rd_arbiter_if #(.AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32)) bus ();

    conv_axi_rd_arbiter #(
        .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .busy(busy), .rid_err(rid_err)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: requests waiting, bursts granted on the port, per-requester in-flight counts.
    ar_t    pend[$];
    ar_t    ar_q[$];
    burst_t infl[$];
    ent_t   ent_q[$];
    bit     m_issue;
    ar_t    m_cur;
    int     m_ptr;
    int     m_out[3];

    int ardy_pct, rbeat_pct, rrdy_pct, err_pct, spur_pct;
    bit r_en, rst_210;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ar_t mk_ar(input int r, input logic [3:0] id, input logic [31:0] addr,
                                  input logic [7:0] len);
        ar_t a;
        a.req = r; a.id = id; a.addr = addr; a.len = len;
        a.size = 3'($urandom); a.burst = 2'($urandom);
        return a;
    endfunction

    function automatic ar_t rnd_ar(input int r);
        return mk_ar(r, 4'($urandom), $urandom, 8'($urandom_range(7)));
    endfunction

    // One clock of stimulus, issued at the falling edge; predicts the DUT's reaction at the next rising edge.
    task automatic step();
        int f[3];
        bit acc, done, rst_now;
        int w, k;
        logic rv, rl;
        logic [5:0] rid;
        logic [1:0] idx;
        ent_t e;
        burst_t b;

        rst_now = rst_210 && m_issue && m_out[0] == 2 && m_out[1] == 1 && m_out[2] == 0;
        if (rst_now) rst_210 = 1'b0;
        ARESET = rst_now;

        for (int i = 0; i < 3; i++) begin
            f[i] = -1;
            for (int p = 0; p < pend.size(); p++) if (f[i] < 0 && pend[p].req == i) f[i] = p;
            bus.S_ARVALID[i] = (f[i] >= 0);
            if (f[i] >= 0) begin
                bus.S_ARID[i*4 +: 4]     = pend[f[i]].id;
                bus.S_ARADDR[i*32 +: 32] = pend[f[i]].addr;
                bus.S_ARLEN[i*8 +: 8]    = pend[f[i]].len;
                bus.S_ARSIZE[i*3 +: 3]   = pend[f[i]].size;
                bus.S_ARBURST[i*2 +: 2]  = pend[f[i]].burst;
            end else begin
                bus.S_ARID[i*4 +: 4]     = 4'($urandom);
                bus.S_ARADDR[i*32 +: 32] = $urandom;
                bus.S_ARLEN[i*8 +: 8]    = 8'($urandom);
                bus.S_ARSIZE[i*3 +: 3]   = 3'($urandom);
                bus.S_ARBURST[i*2 +: 2]  = 2'($urandom);
            end
            bus.S_RREADY[i] = ($urandom_range(99) < rrdy_pct);
        end
        bus.M_ARREADY = ($urandom_range(99) < ardy_pct);

        rv = 1'b0; rl = 1'($urandom); rid = 6'($urandom); k = -1;
        if (r_en && infl.size() > 0 && $urandom_range(99) < rbeat_pct) begin
            k = $urandom_range(infl.size() - 1);
            rid = infl[k].rid; rl = (infl[k].left == 1); rv = 1'b1;
        end else if ($urandom_range(99) < err_pct) begin
            rv = 1'b1; rid = {2'b11, 4'($urandom)};
        end else if ($urandom_range(99) < spur_pct) begin
            for (int i = 2; i >= 0; i--) if (m_out[i] == 0) begin
                rv = 1'b1; rl = 1'b1; rid = {2'(i), 4'($urandom)};
            end
        end
        bus.M_RVALID = rv; bus.M_RID = rid; bus.M_RLAST = rl;
        bus.M_RDATA = $urandom; bus.M_RRESP = 2'($urandom);

        idx       = rid[5:4];
        e.rvalid  = (rv && idx != 2'd3) ? (3'b001 << idx) : 3'b000;
        e.mrready = (idx == 2'd3) ? 1'b1 : bus.S_RREADY[idx];
        done      = rv && e.mrready;
        e.err_next = 1'b0;
        if (!rst_now && done) begin
            if (idx == 2'd3) e.err_next = 1'b1;
            else if (rl && m_out[idx] == 0) e.err_next = 1'b1;
        end
        e.rdata = bus.M_RDATA;
        e.rid   = rid[3:0];

        acc = 1'b0; w = 0;
        if (!m_issue) begin
            for (int j = 0; j < 3; j++) begin
                int c;
                c = (m_ptr + j) % 3;
                if (!acc && f[c] >= 0 && m_out[c] < MAXO) begin acc = 1'b1; w = c; end
            end
        end
        e.arready = acc ? (3'b001 << w) : 3'b000;
        e.arvalid = m_issue;
        e.busy    = m_issue || m_out[0] != 0 || m_out[1] != 0 || m_out[2] != 0;
        e.rst     = rst_now;
        ent_q.push_back(e);

        if (rst_now) begin
            m_issue = 1'b0; m_ptr = 0; m_out = '{0, 0, 0};
            pend.delete(); infl.delete();
        end else begin
            if (m_issue && bus.M_ARREADY) begin
                b.rid = {2'(m_cur.req), m_cur.id}; b.left = int'(m_cur.len) + 1;
                infl.push_back(b);
                m_issue = 1'b0;
            end
            if (done && idx != 2'd3) begin
                if (k >= 0) begin
                    if (infl[k].left == 1) infl.delete(k);
                    else infl[k].left = infl[k].left - 1;
                end
                if (rl && m_out[idx] > 0) m_out[idx]--;
            end
            if (acc) begin
                m_cur = pend[f[w]];
                ar_q.push_back(m_cur);
                pend.delete(f[w]);
                m_issue = 1'b1;
                m_ptr = (w + 1) % 3;
                m_out[w]++;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin @(negedge ACLK); step(); end
    endtask

    task automatic drain(input string name);
        bit idle;
        idle = 1'b0;
        r_en = 1'b1;
        if (ardy_pct < 50) ardy_pct = 70;
        if (rbeat_pct < 50) rbeat_pct = 70;
        if (rrdy_pct < 50) rrdy_pct = 70;
        for (int c = 0; c < 3000 && !idle; c++) begin
            @(negedge ACLK); step();
            idle = pend.size() == 0 && !m_issue && infl.size() == 0 &&
                   m_out[0] == 0 && m_out[1] == 0 && m_out[2] == 0;
        end
        check(name, idle, 1'b1);
        run(2);
    endtask

    // Monitor: compares every sampled cycle against the queued prediction; AR fields checked against the grant queue.
    initial begin : monitor
        ent_t e;
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge ACLK); #2;
            if (ent_q.size() != 0) begin
                e = ent_q.pop_front();
                check("s_arready", bus.S_ARREADY, e.arready);
                check("m_arvalid", bus.M_ARVALID, e.arvalid);
                check("busy", busy, e.busy);
                check("s_rvalid", bus.S_RVALID, e.rvalid);
                check("m_rready", bus.M_RREADY, e.mrready);
                check("rid_err", rid_err, prev_err);
                if (e.rvalid != 3'b000) begin
                    check("s_rdata", bus.S_RDATA, e.rdata);
                    check("s_rid", bus.S_RID, e.rid);
                end
                if (bus.M_ARVALID) begin
                    if (ar_q.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
                    else begin
                        check("m_arid", bus.M_ARID, {2'(ar_q[0].req), ar_q[0].id});
                        check("m_araddr", bus.M_ARADDR, ar_q[0].addr);
                        check("m_arlen", bus.M_ARLEN, ar_q[0].len);
                        check("m_arsize", bus.M_ARSIZE, ar_q[0].size);
                        check("m_arburst", bus.M_ARBURST, ar_q[0].burst);
                        if (bus.M_ARREADY) void'(ar_q.pop_front());
                    end
                end
                if (e.rst) ar_q.delete();
                prev_err = e.err_next;
            end
        end
    end

    initial begin : stimulus
        ARESET = 1'b1;
        bus.S_ARID = '0; bus.S_ARADDR = '0; bus.S_ARLEN = '0; bus.S_ARSIZE = '0;
        bus.S_ARBURST = '0; bus.S_ARVALID = '0; bus.S_RREADY = '0;
        bus.M_ARREADY = 1'b0; bus.M_RID = '0; bus.M_RDATA = '0; bus.M_RRESP = '0;
        bus.M_RLAST = 1'b0; bus.M_RVALID = 1'b0;
        m_issue = 1'b0; m_ptr = 0; m_out = '{0, 0, 0};
        r_en = 1'b0; rst_210 = 1'b0;
        ardy_pct = 100; rbeat_pct = 0; rrdy_pct = 100; err_pct = 0; spur_pct = 0;
        repeat (3) @(posedge ACLK);
        run(3);

        // MR2 alone: one 8-beat burst, ID 1 at 0x100
        rbeat_pct = 100; r_en = 1'b1;
        pend.push_back(mk_ar(1, 4'h1, 32'h100, 8'd7));
        drain("drain_single");

        // All three held valid, shared port always ready
        rbeat_pct = 60; rrdy_pct = 80;
        for (int n = 0; n < 3; n++) for (int i = 0; i < 3; i++) pend.push_back(rnd_ar(i));
        drain("drain_rr");

        // MR1 saturates its limit while MR3 keeps being served
        r_en = 1'b0;
        for (int n = 0; n < 5; n++) pend.push_back(rnd_ar(0));
        for (int n = 0; n < 3; n++) pend.push_back(rnd_ar(2));
        run(40);
        drain("drain_limit");

        // Shared port stalls with an AR pending
        ardy_pct = 0;
        for (int i = 0; i < 3; i++) pend.push_back(rnd_ar(i));
        run(12);
        drain("drain_stall");

        // Bad-index beats and stray RLASTs
        err_pct = 50; spur_pct = 40; r_en = 1'b0;
        run(30);
        err_pct = 10; spur_pct = 10;
        for (int i = 0; i < 3; i++) pend.push_back(rnd_ar(i));
        drain("drain_err");

        // Fully random traffic
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) begin
                ardy_pct = $urandom_range(20, 100); rbeat_pct = $urandom_range(20, 100);
                rrdy_pct = $urandom_range(20, 100); r_en = 1'b1;
            end
            if ($urandom_range(99) < 25) pend.push_back(rnd_ar($urandom_range(2)));
            @(negedge ACLK); step();
        end
        err_pct = 0; spur_pct = 0;
        drain("drain_random");

        // Reset while in ISSUE with outstanding {2,1,0}
        r_en = 1'b0; ardy_pct = 100;
        pend.push_back(rnd_ar(0)); pend.push_back(rnd_ar(0)); pend.push_back(rnd_ar(1));
        rst_210 = 1'b1;
        for (int c = 0; c < 60 && rst_210; c++) begin @(negedge ACLK); step(); end
        check("reset_reached", rst_210, 1'b0);
        run(6);

        @(negedge ACLK); #5;
        check("pending_checks", ent_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
